expression_result_unpacker: RTL

Reader side of the packed 90-bit expression result bus (`{y0,…,y17}`) produced by the expression blocks. It accepts one packed vector per valid/ready handshake and streams its 18 fields out one per cycle, each width-adjusted to a common output width, with field index and last marker. An optional checker compares each field against an expected vector and reports per-field mismatches and a per-vector mismatch count.

---
 rtl/expression_result_unpacker.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/expression_result_unpacker.sv
// expression_result_unpacker
// Reader side of the packed 90-bit expression result bus {y0..y17}.
// Each accepted vector is streamed out one field per cycle, with every field
// sign- or zero-extended to OUT_W bits and tagged with its index and a last
// marker.
// Optional build macro: RESULT_CHECK_EN adds an expected-vector register, a
// per-field comparator (out_mismatch) and a per-vector mismatch count (mm_cnt).
// Without it, in_exp is ignored and both check outputs are tied to zero.

module expression_result_unpacker #(
  parameter int OUT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [89:0]      in_y,
  input  logic [89:0]      in_exp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [4:0]       out_idx,
  output logic             out_last,
  output logic             out_mismatch,
  output logic [4:0]       mm_cnt
);

  typedef enum logic {
    IDLE,
    STREAM
  } state_e;

  localparam logic [4:0] LAST_IDX = 5'd17;

  state_e           state_q, state_d;
  logic [4:0]       idx_q, idx_d;
  logic [89:0]      holdY_q, holdY_d;

  logic             accept;
  logic             handshake;
  logic [5:0]       rawField;
  logic [1:0]       fieldPos;
  logic             fieldSigned;
  logic             signBit;
  logic [OUT_W-1:0] extField;

  // Native field k of a packed vector, right-aligned and zero-padded to 6 bits.
  // Each group of three fields occupies 15 bits: widths 4, 5 and 6 from the top.
  function automatic logic [5:0] selectField(input logic [89:0] v,
                                             input logic [4:0]  k);
    logic [5:0] f;
    f = '0;
    case (k)
      5'd0:    f = {2'b00, v[89:86]};
      5'd1:    f = {1'b0,  v[85:81]};
      5'd2:    f = v[80:75];
      5'd3:    f = {2'b00, v[74:71]};
      5'd4:    f = {1'b0,  v[70:66]};
      5'd5:    f = v[65:60];
      5'd6:    f = {2'b00, v[59:56]};
      5'd7:    f = {1'b0,  v[55:51]};
      5'd8:    f = v[50:45];
      5'd9:    f = {2'b00, v[44:41]};
      5'd10:   f = {1'b0,  v[40:36]};
      5'd11:   f = v[35:30];
      5'd12:   f = {2'b00, v[29:26]};
      5'd13:   f = {1'b0,  v[25:21]};
      5'd14:   f = v[20:15];
      5'd15:   f = {2'b00, v[14:11]};
      5'd16:   f = {1'b0,  v[10:6]};
      5'd17:   f = v[5:0];
      default: f = '0;
    endcase
    return f;
  endfunction

  // Position of field k inside its group: 0 -> 4 bits, 1 -> 5 bits, 2 -> 6 bits.
  function automatic logic [1:0] fieldPosOf(input logic [4:0] k);
    logic [1:0] p;
    case (k)
      5'd0, 5'd3, 5'd6, 5'd9, 5'd12, 5'd15:  p = 2'd0;
      5'd1, 5'd4, 5'd7, 5'd10, 5'd13, 5'd16: p = 2'd1;
      default:                               p = 2'd2;
    endcase
    return p;
  endfunction

  // Fields in odd-numbered groups carry two's-complement values.
  function automatic logic fieldSignedOf(input logic [4:0] k);
    logic s;
    case (k)
      5'd3, 5'd4, 5'd5, 5'd9, 5'd10, 5'd11, 5'd15, 5'd16, 5'd17: s = 1'b1;
      default:                                                   s = 1'b0;
    endcase
    return s;
  endfunction

  assign accept    = (state_q == IDLE) && in_valid;
  assign handshake = (state_q == STREAM) && out_ready;

  // Next-state logic: capture on accept, advance the field index on each handoff.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    holdY_d = holdY_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = STREAM;
          idx_d   = 5'd0;
          holdY_d = in_y;
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = 5'd0;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 5'd0;
      end
    endcase
  end

  // State, index and holding register; reset drops any vector in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 5'd0;
      holdY_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      holdY_q <= holdY_d;
    end
  end

  // Select the current field and extend it to OUT_W (sign-fill for signed groups).
  always_comb begin
    rawField    = selectField(holdY_q, idx_q);
    fieldPos    = fieldPosOf(idx_q);
    fieldSigned = fieldSignedOf(idx_q);
    case (fieldPos)
      2'd0:    signBit = rawField[3];
      2'd1:    signBit = rawField[4];
      default: signBit = rawField[5];
    endcase
    extField = (fieldSigned && signBit) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
    case (fieldPos)
      2'd0:    extField[3:0] = rawField[3:0];
      2'd1:    extField[4:0] = rawField[4:0];
      default: extField[5:0] = rawField;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == STREAM);
  assign out_data  = out_valid ? extField : {OUT_W{1'b0}};
  assign out_idx   = idx_q;
  assign out_last  = out_valid && (idx_q == LAST_IDX);

`ifdef RESULT_CHECK_EN
  logic [89:0] holdExp_q, holdExp_d;
  logic [4:0]  mmCnt_q, mmCnt_d;
  logic [5:0]  expField;
  logic        fieldMismatch;

  // Compare the current field against the expected vector on its native width
  // and maintain the running mismatch count for the vector in flight.
  always_comb begin
    expField      = selectField(holdExp_q, idx_q);
    fieldMismatch = (rawField != expField);
    holdExp_d     = holdExp_q;
    mmCnt_d       = mmCnt_q;
    if (accept) begin
      holdExp_d = in_exp;
      mmCnt_d   = 5'd0;
    end else if (handshake && fieldMismatch) begin
      mmCnt_d = mmCnt_q + 5'd1;
    end
  end

  // Expected-vector and mismatch-count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      holdExp_q <= '0;
      mmCnt_q   <= 5'd0;
    end else begin
      holdExp_q <= holdExp_d;
      mmCnt_q   <= mmCnt_d;
    end
  end

  // The count already includes the field being handed off this cycle, so the
  // final total is visible during the last handoff as well as afterwards.
  assign out_mismatch = out_valid && fieldMismatch;
  assign mm_cnt       = mmCnt_q + {4'd0, handshake && fieldMismatch};
`else
  logic unusedExp;

  assign unusedExp    = ^in_exp;
  assign out_mismatch = 1'b0;
  assign mm_cnt       = 5'd0;
`endif

endmodule
